// File: rtl/button_pulse_gen_pkg.sv
// rtl/button_pulse_gen_pkg.sv - shared state encoding and default timing for the button front-end
package button_pulse_gen_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_RELEASED = 2'd0,
    ST_DELAY    = 2'd1,
    ST_REPEAT   = 2'd2
  } btn_state_e;

  // Defaults sized for a 50 MHz system clock
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_EN       = 1;
  localparam int DEF_REPEAT_DELAY    = 25_000_000;
  localparam int DEF_REPEAT_RATE     = 5_000_000;
  localparam int DEF_CNT_W           = 25;

endpackage

// File: rtl/button_pulse_gen_if.sv
// rtl/button_pulse_gen_if.sv - raw button inputs and clean step/level outputs
interface button_pulse_gen_if;

  logic button_inc;
  logic button_dec;
  logic inc_pulse;
  logic dec_pulse;
  logic inc_held;
  logic dec_held;

  modport master (
    output button_inc, button_dec,
    input  inc_pulse, dec_pulse, inc_held, dec_held
  );

  modport slave (
    input  button_inc, button_dec,
    output inc_pulse, dec_pulse, inc_held, dec_held
  );

endinterface

// File: rtl/button_pulse_gen_btn_channel.sv
// rtl/button_pulse_gen_btn_channel.sv - one button: synchroniser, debounce and press/repeat FSM
module btn_channel
  import button_pulse_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN       = DEF_REPEAT_EN,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic pulse,
  output logic held
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] db_cnt;
  btn_state_e       state;
  btn_state_e       state_nxt;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_nxt;
  logic             pulse_nxt;

  // Pin is active-low, so the debounced level compares against the inverted s2
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      db_cnt <= '0;
      held   <= 1'b0;
    end else begin
      s1 <= button;
      s2 <= s1;
      if (~s2 != held) begin
        if (db_cnt == DB_LAST) begin
          held   <= ~s2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + CNT_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RELEASED;
      timer <= '0;
      pulse <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      pulse <= pulse_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    pulse_nxt = 1'b0;
    case (state)
      ST_RELEASED: begin
        timer_nxt = '0;
        if (held) begin
          pulse_nxt = 1'b1;
          state_nxt = ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (!held) begin
          timer_nxt = '0;
          state_nxt = ST_RELEASED;
        end else if (timer == RD_LAST) begin
          // Without auto-repeat the timer still clears so it never wraps
          timer_nxt = '0;
          if (REPEAT_EN != 0) begin
            pulse_nxt = 1'b1;
            state_nxt = ST_REPEAT;
          end
        end else begin
          timer_nxt = timer + CNT_W'(1);
        end
      end
      ST_REPEAT: begin
        if (!held) begin
          timer_nxt = '0;
          state_nxt = ST_RELEASED;
        end else if (timer == RR_LAST) begin
          timer_nxt = '0;
          pulse_nxt = 1'b1;
        end else begin
          timer_nxt = timer + CNT_W'(1);
        end
      end
      default: begin
        timer_nxt = '0;
        state_nxt = ST_RELEASED;
      end
    endcase
  end

endmodule

// File: rtl/button_pulse_gen.sv
// rtl/button_pulse_gen.sv - two debounced button channels with conflicting pulses dropped
module button_pulse_gen
  import button_pulse_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN       = DEF_REPEAT_EN,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  button_pulse_gen_if.slave   bus
);

  logic inc_raw;
  logic dec_raw;

  btn_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_EN       (REPEAT_EN),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_RATE     (REPEAT_RATE),
    .CNT_W           (CNT_W)
  ) u_inc (
    .clk    (clk),
    .rst    (rst),
    .button (bus.button_inc),
    .pulse  (inc_raw),
    .held   (bus.inc_held)
  );

  btn_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_EN       (REPEAT_EN),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_RATE     (REPEAT_RATE),
    .CNT_W           (CNT_W)
  ) u_dec (
    .clk    (clk),
    .rst    (rst),
    .button (bus.button_dec),
    .pulse  (dec_raw),
    .held   (bus.dec_held)
  );

  // Coincident requests cancel; neither is deferred
  assign bus.inc_pulse = inc_raw & ~dec_raw;
  assign bus.dec_pulse = dec_raw & ~inc_raw;

endmodule

// File: tb/tb_button_pulse_gen.sv
// tb/tb_button_pulse_gen.sv - randomized and directed bench against a behavioural model
module tb_button_pulse_gen;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  logic clk = 1'b0;
  logic rst;
  logic b_inc;
  logic b_dec;

  int total = 0;
  int bad   = 0;

  button_pulse_gen_if bi ();
  button_pulse_gen_if bi0 ();

  assign bi.button_inc  = b_inc;
  assign bi.button_dec  = b_dec;
  assign bi0.button_inc = b_inc;
  assign bi0.button_dec = b_dec;

  button_pulse_gen #(
    .DEBOUNCE_CYCLES (D), .REPEAT_EN (1), .REPEAT_DELAY (RD),
    .REPEAT_RATE (RR), .CNT_W (8)
  ) dut (
    .clk (clk), .rst (rst), .bus (bi.slave)
  );

  button_pulse_gen #(
    .DEBOUNCE_CYCLES (D), .REPEAT_EN (0), .REPEAT_DELAY (RD),
    .REPEAT_RATE (RR), .CNT_W (8)
  ) dut0 (
    .clk (clk), .rst (rst), .bus (bi0.slave)
  );

  always #10 clk = ~clk;

  // Model state indexed [unit][channel]; unit 0 repeats, unit 1 does not; channel 0 = inc
  logic m_sh     [2][2][2];
  logic m_held   [2][2];
  int   m_streak [2][2];
  logic m_last   [2][2];
  logic m_act    [2][2];
  int   m_k      [2][2];
  logic m_p      [2][2];

  int idx;
  int cnt_p   [2][2];
  int first_p [2][2];
  int first_h [2][2];
  int saw_h   [2][2];
  int pq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at idx %0d: got %0d expected %0d", tag, idx, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      for (int c = 0; c < 2; c++) begin
        m_sh[u][c][0] = 1'b1;
        m_sh[u][c][1] = 1'b1;
        m_held[u][c]   = 1'b0;
        m_streak[u][c] = 0;
        m_last[u][c]   = 1'b0;
        m_act[u][c]    = 1'b0;
        m_k[u][c]      = 0;
        m_p[u][c]      = 1'b0;
      end
    end
  endtask

  // Held flips after D consecutive identical synchronised samples disagree with it;
  // pulses land at press offsets 0, RD, RD+RR, ... while the FSM sees held
  task automatic model_step();
    logic raw;
    logic pressed;
    if (!rst) begin
      model_reset();
      return;
    end
    for (int u = 0; u < 2; u++) begin
      for (int c = 0; c < 2; c++) begin
        raw = (c == 0) ? b_inc : b_dec;
        if (m_held[u][c]) begin
          if (!m_act[u][c]) begin
            m_act[u][c] = 1'b1;
            m_k[u][c]   = 0;
            m_p[u][c]   = 1'b1;
          end else begin
            m_k[u][c]++;
            m_p[u][c] = (u == 0) && (m_k[u][c] >= RD) && ((m_k[u][c] - RD) % RR == 0);
          end
        end else begin
          m_act[u][c] = 1'b0;
          m_p[u][c]   = 1'b0;
        end
        pressed = ~m_sh[u][c][1];
        m_streak[u][c] = (pressed == m_last[u][c]) ? m_streak[u][c] + 1 : 1;
        m_last[u][c]   = pressed;
        if (pressed != m_held[u][c] && m_streak[u][c] >= D) m_held[u][c] = pressed;
        m_sh[u][c][1] = m_sh[u][c][0];
        m_sh[u][c][0] = raw;
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0] o [2];
    logic [3:0] e;
    o[0] = {bi.inc_pulse,  bi.dec_pulse,  bi.inc_held,  bi.dec_held};
    o[1] = {bi0.inc_pulse, bi0.dec_pulse, bi0.inc_held, bi0.dec_held};
    for (int u = 0; u < 2; u++) begin
      e = {m_p[u][0] & ~m_p[u][1], m_p[u][1] & ~m_p[u][0], m_held[u][0], m_held[u][1]};
      chk(u == 0 ? "outs_rep" : "outs_norep", 32'(o[u]), 32'(e));
      for (int c = 0; c < 2; c++) begin
        if (o[u][3-c] === 1'b1) begin
          cnt_p[u][c]++;
          if (first_p[u][c] < 0) first_p[u][c] = idx;
          if (u == 0 && c == 0) pq.push_back(idx);
        end
        if (o[u][1-c] === 1'b1) begin
          saw_h[u][c] = 1;
          if (first_h[u][c] < 0) first_h[u][c] = idx;
        end
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
      idx++;
    end
  endtask

  task automatic clear_stats();
    idx = 0;
    pq.delete();
    for (int u = 0; u < 2; u++) begin
      for (int c = 0; c < 2; c++) begin
        cnt_p[u][c]   = 0;
        first_p[u][c] = -1;
        first_h[u][c] = -1;
        saw_h[u][c]   = 0;
      end
    end
  endtask

  initial begin
    int offs [6];
    offs = '{0, 20, 28, 36, 44, 52};
    rst   = 1'b0;
    b_inc = 1'b1;
    b_dec = 1'b1;
    model_reset();
    clear_stats();
    #1;
    chk("in_reset", 32'({bi.inc_pulse, bi.dec_pulse, bi.inc_held, bi.dec_held}), 32'd0);
    chk("in_reset_norep", 32'({bi0.inc_pulse, bi0.dec_pulse, bi0.inc_held, bi0.dec_held}), 32'd0);
    #99;
    rst = 1'b1;
    cyc(5);
    chk("idle", 32'({bi.inc_pulse, bi.dec_pulse, bi.inc_held, bi.dec_held}), 32'd0);

    // Clean short press
    clear_stats();
    b_inc = 1'b0;
    cyc(10);
    b_inc = 1'b1;
    cyc(20);
    chk("press_cnt", cnt_p[0][0], 1);
    chk("press_lat", first_p[0][0], 6);
    chk("press_held_lat", first_h[0][0], 5);
    chk("press_dec_none", cnt_p[0][1], 0);

    // Long hold: auto-repeat vs single pulse
    clear_stats();
    b_inc = 1'b0;
    cyc(60);
    b_inc = 1'b1;
    cyc(20);
    chk("rep_cnt", cnt_p[0][0], 6);
    chk("norep_cnt", cnt_p[1][0], 1);
    chk("rep_qsize", pq.size(), 6);
    for (int i = 0; i < 6 && i < pq.size(); i++) chk("rep_off", pq[i], 6 + offs[i]);

    // Bouncing dec press settling low
    clear_stats();
    for (int t = 0; t < 12; t++) begin
      b_dec = ((t / 2) % 2 == 0) ? 1'b0 : 1'b1;
      cyc(1);
    end
    b_dec = 1'b0;
    cyc(18);
    b_dec = 1'b1;
    cyc(20);
    chk("bounce_cnt", cnt_p[0][1], 1);
    chk("bounce_lat", first_p[0][1], 18);

    // Short glitch
    clear_stats();
    b_dec = 1'b0;
    cyc(3);
    b_dec = 1'b1;
    cyc(15);
    chk("glitch_cnt", cnt_p[0][1], 0);
    chk("glitch_held", saw_h[0][1], 0);

    // Simultaneous press, then dec released
    clear_stats();
    b_inc = 1'b0;
    b_dec = 1'b0;
    cyc(40);
    chk("sim_inc_cnt", cnt_p[0][0], 0);
    chk("sim_dec_cnt", cnt_p[0][1], 0);
    chk("sim_held", 32'({bi.inc_held, bi.dec_held}), 32'd3);
    b_dec = 1'b1;
    cyc(30);
    b_inc = 1'b1;
    cyc(20);
    chk("resume_cnt", cnt_p[0][0], 4);
    chk("resume_first", first_p[0][0], 50);
    chk("resume_dec_cnt", cnt_p[0][1], 0);

    // Reset while holding in repeat
    clear_stats();
    b_inc = 1'b0;
    cyc(40);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_async", 32'({bi.inc_pulse, bi.dec_pulse, bi.inc_held, bi.dec_held}), 32'd0);
    cyc(3);
    rst = 1'b1;
    clear_stats();
    cyc(30);
    chk("rst_repress_lat", first_p[0][0], 6);
    b_inc = 1'b1;
    cyc(20);

    // Randomized segments
    for (int s = 0; s < 80; s++) begin
      b_inc = 1'($urandom_range(0, 1));
      b_dec = 1'($urandom_range(0, 1));
      cyc($urandom_range(1, 40));
    end
    b_inc = 1'b1;
    b_dec = 1'b1;
    cyc(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_pulse_gen.md
Name: button_pulse_gen

Overview:
- Upstream front-end for the PWM duty-cycle stage. Takes the raw, active-low, bouncing button_inc / button_dec pins.
- Produces clean single-cycle active-high step pulses, with optional auto-repeat while a button is held.
- Its outputs drive the PWM's increment/decrement inputs directly, so the PWM never sees metastable or bouncing levels.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles needed before the debounced level changes (20 ms at 50 MHz); must be >= 2.
- REPEAT_EN, 1: 1 enables auto-repeat while held; 0 gives one pulse per press only.
- REPEAT_DELAY, 25_000_000: cycles from the initial pulse to the first repeat pulse.
- REPEAT_RATE, 5_000_000: cycles between subsequent repeat pulses.
- CNT_W, 25: width of each channel's debounce counter and repeat counter; must hold the largest of the three counts above.

Ports:
- clk  in  1  system clock, single domain.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- button_inc  in  1  raw increment button, active-low (1 = released), asynchronous to clk.
- button_dec  in  1  raw decrement button, active-low, asynchronous to clk.
- inc_pulse  out  1  one-cycle active-high increment request.
- dec_pulse  out  1  one-cycle active-high decrement request.
- inc_held  out  1  debounced level, 1 = inc pressed.
- dec_held  out  1  debounced level, 1 = dec pressed.

Behaviour:
- Reset (rst=0, async): both sync flops = 1; debounced levels = released; counters = 0; FSMs = RELEASED; all four outputs = 0. Outputs are held at 0 while rst=0.
- Per channel, synchroniser: two flops, s1 then s2.
- Per channel, debounce counter:
  - each edge where s2 differs from the debounced level: if cnt == DEBOUNCE_CYCLES-1, the level takes s2 and cnt clears; otherwise cnt increments;
  - any edge where s2 equals the level clears cnt.
  - Result: a glitch shorter than DEBOUNCE_CYCLES cycles never changes the level.
- Latency: a press stable before edge E0 updates held after E(D+1) and raises pulse after E(D+2), where D = DEBOUNCE_CYCLES. Pulse width is exactly 1 cycle.
- Per-channel FSM, all outputs registered:
  - RELEASED: on held=1, assert pulse, clear the repeat timer, go to DELAY.
  - DELAY: timer counts; at REPEAT_DELAY-1 assert pulse, clear timer, go to REPEAT. If REPEAT_EN=0, stay in DELAY with no pulses.
  - REPEAT: timer counts; at REPEAT_RATE-1 assert pulse, clear timer, stay in REPEAT.
  - Any state with held=0: go to RELEASED, clear the timer, no pulse that cycle. Release has priority over a coincident repeat tick.
  - Repeat pulses therefore sit at offsets 0, RD, RD+RR, RD+2RR, ... from the initial pulse.
- Arbitration: if both channels would pulse in the same cycle, both pulses are dropped, not deferred. The channel FSMs and timers still advance normally. inc_held / dec_held are unaffected.
- Reset mid-hold: the pulse drops immediately. After rst returns to 1 with the button still low, the press is treated as new: initial pulse after E(D+2) measured from release of reset.
- Counters saturate nowhere and never wrap: every count clears on its terminal value.

Decomposition:
- Shared package: FSM state encoding (RELEASED, DELAY, REPEAT), a 2-bit localparam set, and default timing constants at 50 MHz.
- One sub-module, btn_channel: sync + debounce + FSM for one button, parameterised identically.
- Top instantiates two btn_channel instances plus the arbitration logic.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8; 20 ns clock; rst pulsed low 100 ns then high):
- Reset: during and after reset, with buttons idle high -> inc_pulse, dec_pulse, inc_held and dec_held all 0; assert rst=0 asynchronously between edges -> outputs 0 before the next edge.
- Clean press: button_inc=0 before edge E0, held 10 cycles -> inc_held=1 after E5, exactly one inc_pulse after E6, dec_pulse never asserted; with REPEAT_EN=0, still exactly one pulse for a 60-cycle hold.
- Bounce and glitch:
  - button_dec toggled every 2 cycles for 12 cycles, then held low -> exactly one dec_pulse, 6 edges after the last toggle;
  - a 3-cycle low glitch -> no pulse, dec_held stays 0.
- Auto-repeat: button_inc low for 60 cycles after the first pulse -> pulses at offsets 0, 20, 28, 36, 44, 52 (6 total); none after inc_held falls.
- Simultaneous press: both buttons low at the same edge for 40 cycles -> inc_held = dec_held = 1, zero pulses on either output. Then release dec -> inc repeat pulses resume on the original 8-cycle cadence.
- Reset mid-hold: rst=0 while button_inc is held in REPEAT -> outputs 0 immediately. After rst=1 with the button still low -> a new initial inc_pulse after E6 measured from reset release.
